// File: rtl/fetch_refill_ctrl.sv
// Instruction-fetch miss/refill controller: turns I-cache misses into 16-beat line
// reads, writes returned beats into the cache and keeps the snoop table in step.
module fetch_refill_ctrl #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        miss_valid,
    input  logic [31:0] miss_addr,
    output logic        miss_ready,
    output logic        miss_merged,
    output logic        snoop_wea,
    output logic [31:0] snoop_addra,
    output logic        snoop_web,
    output logic [31:0] snoop_q_addr,
    input  logic        snoop_q_hit,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [31:0] mem_araddr,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rlast,
    output logic        refill_wen,
    output logic [31:0] refill_addr,
    output logic [31:0] refill_data,
    output logic        refill_done,
    output logic        refill_err
);

    localparam int               PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [2:0]       OUTST_MAX = 3'(MAX_OUTSTANDING);

    typedef enum logic {
        AR_IDLE,
        AR_BUSY
    } ar_state_t;

    ar_state_t        ar_state_reg, ar_state_next;
    logic [31:0]      araddr_reg;
    logic [2:0]       outst_reg, outst_next;
    logic [3:0]       beat_reg;
    logic             err_reg;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [25:0]      tag_mem [MAX_OUTSTANDING];
    logic [25:0]      tag_head;

    logic acc, issue, merge, beat_fire, line_end, ar_busy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Accept / merge / issue decode; a full controller refuses even mergeable misses.
    assign ar_busy      = (ar_state_reg == AR_BUSY);
    assign miss_ready   = ~ar_busy & (outst_reg < OUTST_MAX);
    assign acc          = miss_valid & miss_ready;
    assign merge        = acc & snoop_q_hit;
    assign issue        = acc & ~snoop_q_hit;
    assign miss_merged  = merge;
    assign snoop_wea    = issue;
    assign snoop_addra  = {miss_addr[31:6], 6'b0};
    assign snoop_q_addr = miss_addr;

    always_comb begin
        ar_state_next = ar_state_reg;
        case (ar_state_reg)
            AR_IDLE: if (issue)       ar_state_next = AR_BUSY;
            AR_BUSY: if (mem_arready) ar_state_next = AR_IDLE;
            default:                  ar_state_next = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state_reg <= AR_IDLE;
        end else begin
            ar_state_reg <= ar_state_next;
        end
    end

    // Address is only loaded from idle, so it stays stable while arvalid is high.
    always_ff @(posedge clk) begin
        if (issue) begin
            araddr_reg <= {miss_addr[31:6], 6'b0};
        end
    end

    assign mem_arvalid = ar_busy;
    assign mem_araddr  = araddr_reg;

    // R stage: line end is decided by the beat count alone, never by rlast.
    assign mem_rready  = (outst_reg != 3'd0);
    assign beat_fire   = mem_rvalid & mem_rready;
    assign line_end    = beat_fire & (beat_reg == 4'd15);
    assign tag_head    = tag_mem[rd_ptr_reg];
    assign refill_wen  = beat_fire;
    assign refill_addr = {tag_head, beat_reg, 2'b00};
    assign refill_data = mem_rdata;
    assign refill_done = line_end;
    assign snoop_web   = line_end;
    assign refill_err  = err_reg;

    always_comb begin
        outst_next = outst_reg;
        case ({issue, line_end})
            2'b10:   outst_next = outst_reg + 3'd1;
            2'b01:   outst_next = outst_reg - 3'd1;
            default: outst_next = outst_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outst_reg  <= 3'd0;
            beat_reg   <= 4'd0;
            err_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            outst_reg <= outst_next;
            if (beat_fire) begin
                beat_reg <= beat_reg + 4'd1;
                if (mem_rlast != (beat_reg == 4'd15)) begin
                    err_reg <= 1'b1;
                end
            end
            if (issue) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (line_end) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end

    // Tag FIFO storage; a push and pop in the same cycle touch different slots.
    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (issue && (wr_ptr_reg == PTR_W'(gi))) begin
                    tag_mem[gi] <= miss_addr[31:6];
                end
            end
        end
    endgenerate

endmodule
